// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_out_stage.sv
// Single-entry valid/ready holding register between fetch and decode.
module fetch_out_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [31:0] pc_o
);
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d, pc_q, pc_d;

  // Flush wins over load; a consumed word with no replacement empties the stage.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/instruction_memory.sv
// Small combinational program ROM; words outside the 32-byte image or misaligned read as zero.
module instruction_memory (
  input  logic [31:0] sel,
  output logic [31:0] out
);
  logic [31:0] word;

  always_comb begin
    word = 32'h0;
    case (sel[4:2])
      3'd0: word = 32'h20000003;
      3'd1: word = 32'h20210004;
      3'd2: word = 32'h00221820;
      3'd3: word = 32'hAC030008;
      3'd4: word = 32'h8C040008;
      3'd5: word = 32'h10800002;
      3'd6: word = 32'h08000000;
      default: word = 32'h00000000;
    endcase
  end

  assign out = (sel[31:5] == 27'd0 && sel[1:0] == 2'b00) ? word : 32'h0;
endmodule

// File: rtl/fetch_unit.sv
// Fetch controller: owns the PC, sequences instruction_memory, handles redirects,
// end-of-program stop and misaligned-target faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'd0,
  parameter logic [31:0] END_ADDR  = 32'd28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_sel,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        done,
  output logic        fault
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         done_q, fault_q;
  logic         load, flush, load_opp;

  assign load_opp = !inst_valid || inst_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = BOOT_ADDR;
          state_d = RUN;
        end
      end
      RUN, DONE: begin
        // Redirect beats the normal load; a bad target leaves the PC where it was.
        if (redirect_valid) begin
          flush = 1'b1;
          if (misaligned(redirect_target)) begin
            state_d = FAULT;
          end else begin
            pc_d    = redirect_target;
            state_d = RUN;
          end
        end else if (state_q == RUN && load_opp) begin
          if (pc_q != END_ADDR) begin
            load = 1'b1;
            pc_d = pc_q + INSTR_BYTES;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: ;
    endcase
  end

  // DONE is only entered on a cycle that leaves the output stage empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= (state_d == DONE);
      fault_q <= (state_d == FAULT);
    end
  end

  fetch_out_stage u_out (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (inst_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .valid_o (inst_valid),
    .data_o  (inst_out),
    .pc_o    (inst_pc)
  );

  assign imem_sel = pc_q;
  assign done     = done_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Random and directed stimulus for fetch_unit, checked each cycle against a behavioural model.
module tb_fetch_unit;
  localparam longint BOOT = 0;
  localparam longint ENDA = 28;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, inst_ready;
  logic [31:0] redirect_target, imem_sel, imem_data, inst_out, inst_pc;
  logic        inst_valid, done, fault;

  always #5 clk = ~clk;

  fetch_unit #(.BOOT_ADDR(32'd0), .END_ADDR(32'd28)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_sel(imem_sel), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .done(done), .fault(fault)
  );

  instruction_memory imem (.sel(imem_sel), .out(imem_data));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Program image as the bench understands it.
  function automatic longint word_at(input longint a);
    longint img [7] = '{32'h20000003, 32'h20210004, 32'h00221820, 32'hAC030008,
                        32'h8C040008, 32'h10800002, 32'h08000000};
    if (a % 4 != 0 || a >= 28) return 0;
    return img[a / 4];
  endfunction

  // Reference model: a mode, a PC and a queue holding at most one undelivered word.
  int     m_mode;
  longint m_pc;
  longint hq_pc[$], hq_w[$];
  longint delivered[$];

  function automatic void m_reset();
    m_mode = M_IDLE; m_pc = BOOT; hq_pc.delete(); hq_w.delete();
  endfunction

  function automatic void m_step(input logic st, input logic rv, input longint tgt, input logic rdy);
    bit consumed = (hq_pc.size() > 0) && rdy;
    if (m_mode == M_FAULT) return;
    if (consumed) delivered.push_back(hq_pc[0]);
    if (m_mode == M_IDLE) begin
      if (st) begin m_pc = BOOT; m_mode = M_RUN; end
      return;
    end
    if (rv) begin
      hq_pc.delete(); hq_w.delete();
      if (tgt % 4 != 0) m_mode = M_FAULT;
      else begin m_pc = tgt; m_mode = M_RUN; end
      return;
    end
    if (m_mode == M_RUN && (hq_pc.size() == 0 || rdy)) begin
      hq_pc.delete(); hq_w.delete();
      if (m_pc != ENDA) begin
        hq_pc.push_back(m_pc); hq_w.push_back(word_at(m_pc));
        m_pc = (m_pc + 4) % (64'd1 << 32);
      end else m_mode = M_DONE;
    end
  endfunction

  task automatic compare();
    bit hv = hq_pc.size() > 0;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, hv});
    if (hv) begin
      chk("inst_pc", inst_pc, hq_pc[0][31:0]);
      chk("inst_out", inst_out, hq_w[0][31:0]);
    end
    chk("imem_sel", imem_sel, m_pc[31:0]);
    chk("done", {31'd0, done}, {31'd0, (m_mode == M_DONE) && !hv});
    chk("fault", {31'd0, fault}, {31'd0, m_mode == M_FAULT});
  endtask

  // Called at a negedge: drive, predict, advance one clock, compare.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] tgt, input logic rdy);
    start = st; redirect_valid = rv; redirect_target = tgt; inst_ready = rdy;
    m_step(st, rv, {32'd0, tgt}, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  initial begin
    int bound;
    logic [31:0] tgt;
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; inst_ready = 1'b0;
    m_reset();
    @(negedge clk);
    compare();
    chk("reset_out", inst_out, 32'h0);
    chk("reset_pc", inst_pc, 32'h0);
    reset = 1'b0;

    // Straight run 0..24, then DONE.
    delivered.delete();
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    chk("stream_len", delivered.size(), 32'd7);
    chk("done_after_run", {31'd0, done}, 32'd1);

    // Redirect from DONE to 8, then stall 3 cycles while PC 4 is held.
    cyc(0, 1, 32'd8, 1);
    chk("done_fell", {31'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'd0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("stall_pc4", inst_pc, 32'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("stall_word", inst_out, 32'h20210004);
    cyc(0, 0, 0, 1);
    chk("after_stall", inst_pc, 32'd8);

    // Redirect on the same cycle PC 24 is handed off.
    bound = 0;
    while (!(hq_pc.size() > 0 && hq_pc[0] == 24) && bound < 20) begin cyc(0, 0, 0, 1); bound++; end
    chk("reach_pc24", {31'd0, bound < 20}, 32'd1);
    delivered.delete();
    cyc(0, 1, 32'd8, 1);
    chk("pc24_delivered", delivered.size(), 32'd1);
    cyc(0, 0, 0, 1);
    chk("redirect_target", inst_pc, 32'd8);

    // PC wrap from the top of the address space.
    cyc(0, 1, 32'hFFFFFFFC, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 7) * 4);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset with a word held.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_before_rst", {31'd0, inst_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_sel", imem_sel, 32'd0);
    m_reset();
    @(negedge clk);
    compare();
    reset = 1'b0;

    // Misaligned redirect is terminal.
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'd6, 1);
    chk("fault_set", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 30; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 7) * 4), $urandom_range(0, 1));
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
